// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame
//  Purpose  : Oversampling UART receiver. Deserialises start / data (LSB
//             first) / optional parity / stop frames into P_DATA and reports
//             the frame outcome as a one-cycle pulse on exactly one of
//             Data_Valid, Par_Err or Stp_Err.
//  Options  : UART_RX_MAJORITY_EN - when defined, each bit is the majority of
//             the samples at edge_cnt S-1, S and S+1, and every decision is
//             taken at S+1. Otherwise a single sample at S is used.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  Busy
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]  BC_ONE   = BIT_CNT_W'(1);
    localparam logic [PRESCALE_W-1:0] PS_ONE   = PRESCALE_W'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]            state;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_err_q;
    logic [DATA_WIDTH-1:0] shreg;

    logic [PRESCALE_W-1:0] half_pt;
    logic [PRESCALE_W-1:0] decide_pt;
    logic                  bit_val;
    logic                  decide;
    logic                  bit_end;
    logic                  parity_exp;

    // Sample point sits in the middle of the bit; configuration is frozen
    // for the whole frame so the timing cannot shift under us.
    assign half_pt = prescale_q >> 1;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous line samples so that at S+1 we hold S-1, S, S+1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], RX_IN};
        end
    end

    assign decide_pt = half_pt + PS_ONE;
    assign bit_val   = (hist[1] & hist[0]) | (hist[1] & RX_IN) | (hist[0] & RX_IN);
`else
    assign decide_pt = half_pt;
    assign bit_val   = RX_IN;
`endif

    assign decide     = (edge_cnt == decide_pt);
    assign bit_end    = (edge_cnt == (prescale_q - PS_ONE));
    assign parity_exp = (^shreg) ^ par_typ_q;
    assign Busy       = (state != ST_IDLE);

    // Frame sequencer: bit timing counters, shift register and outcome flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_err_q  <= 1'b0;
            shreg      <= '0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;

            if (state != ST_IDLE) begin
                if (bit_end) begin
                    edge_cnt <= '0;
                    bit_cnt  <= bit_cnt + BC_ONE;
                end else begin
                    edge_cnt <= edge_cnt + PS_ONE;
                end
            end

            case (state)
                ST_IDLE: begin
                    // The cycle that sees the falling edge is edge 0.
                    if (!RX_IN) begin
                        state      <= ST_START;
                        edge_cnt   <= PS_ONE;
                        bit_cnt    <= '0;
                        prescale_q <= Prescale;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_err_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    // A line that is high again mid-bit was only a glitch.
                    if (decide && bit_val) begin
                        state    <= ST_IDLE;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                    end else if (bit_end) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shreg[bit_cnt] <= bit_val;
                    end
                    if (bit_end && (bit_cnt == LAST_BIT)) begin
                        state   <= par_en_q ? ST_PARITY : ST_STOP;
                        bit_cnt <= '0;
                    end
                end
                ST_PARITY: begin
                    if (decide && (bit_val != parity_exp)) begin
                        par_err_q <= 1'b1;
                    end
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so a following start edge is seen.
                    if (decide) begin
                        state    <= ST_IDLE;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!bit_val) begin
                            Stp_Err <= 1'b1;
                        end else if (par_err_q) begin
                            Par_Err <= 1'b1;
                        end else begin
                            Data_Valid <= 1'b1;
                            P_DATA     <= shreg;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_frame
//  Purpose  : Directed self-checking bench for uart_rx_frame with an
//             expected-event scoreboard (flags, P_DATA and pulse timing).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    localparam logic [2:0] F_DV = 3'b100;
    localparam logic [2:0] F_PE = 3'b010;
    localparam logic [2:0] F_SE = 3'b001;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b0;
    logic          RX_IN    = 1'b1;
    logic [PW-1:0] Prescale = 6'd8;
    logic          PAR_EN   = 1'b0;
    logic          PAR_TYP  = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Par_Err;
    logic          Stp_Err;
    logic          Busy;

    uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    typedef struct packed {
        logic [2:0]  flags;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  last_good = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Any outcome pulse must match the next scoreboard entry exactly.
    always @(negedge CLK) begin
        if (Data_Valid === 1'b1 || Par_Err === 1'b1 || Stp_Err === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_flag", {29'b0, Data_Valid, Par_Err, Stp_Err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("flags", {29'b0, Data_Valid, Par_Err, Stp_Err}, {29'b0, mon_e.flags});
                chk("p_data", {24'b0, P_DATA}, {24'b0, mon_e.data});
                chk("latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b, input int p, input logic spike);
        for (int i = 0; i < p; i++) begin
            RX_IN = (spike && (i == p / 2)) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic bad_par, input logic stop_v,
                              input logic spike, input logic perturb);
        int   p;
        exp_t e;
        logic [PW-1:0] ps_saved;
        assert (Prescale[0] == 1'b0 && Prescale >= 8) else begin
            $display("FAIL prescale_cfg observed=%0d", Prescale);
            $fatal(1, "invalid Prescale");
        end
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        ps_saved = Prescale;
        p        = int'(Prescale);
        e.cyc    = cyc + 1 + (1 + DW + int'(pen)) * p + p / 2 + MAJ;
        if (!stop_v) begin
            e.flags = F_SE;
            e.data  = last_good;
        end else if (pen && bad_par) begin
            e.flags = F_PE;
            e.data  = last_good;
        end else begin
            e.flags   = F_DV;
            e.data    = d;
            last_good = d;
        end
        sb.push_back(e);
        send_bit(1'b0, p, 1'b0);
        if (perturb) begin
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
            Prescale = (p == 8) ? 6'd16 : 6'd8;
        end
        for (int i = 0; i < DW; i++) send_bit(d[i], p, spike);
        if (pen) send_bit((^d) ^ ptyp ^ bad_par, p, 1'b0);
        send_bit(stop_v, p, 1'b0);
        RX_IN    = 1'b1;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        Prescale = ps_saved;
    endtask

    initial begin
        // Reset state
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_p_data", {24'b0, P_DATA}, 32'd0);
        chk("rst_dv", {31'b0, Data_Valid}, 32'd0);
        chk("rst_pe", {31'b0, Par_Err}, 32'd0);
        chk("rst_se", {31'b0, Stp_Err}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        RST = 1'b1;
        idle(4);

        // Plain frame, no parity
        Prescale = 6'd8;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("a5_pending", sb.size(), 32'd0);
        chk("a5_busy", {31'b0, Busy}, 32'd0);

        // Even parity good (with mid-frame config changes), then bad parity
        Prescale = 6'd16;
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("par_ok_pending", sb.size(), 32'd0);
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_bad_pending", sb.size(), 32'd0);
        chk("par_bad_p_data", {24'b0, P_DATA}, 32'h3C);

        // Stop error, then recovery
        Prescale = 6'd8;
        idle(4);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(16);
        chk("stp_pending", sb.size(), 32'd0);
        chk("stp_busy", {31'b0, Busy}, 32'd0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("recover_pending", sb.size(), 32'd0);

        // Short low glitch on idle line
        idle(4);
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        chk("glitch_busy_hi", {31'b0, Busy}, 32'd1);
        repeat (8) @(negedge CLK);
        chk("glitch_busy_lo", {31'b0, Busy}, 32'd0);
        chk("glitch_p_data", {24'b0, P_DATA}, 32'h0F);

        // Back-to-back frames
        Prescale = 6'd32;
        idle(4);
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b_pending", sb.size(), 32'd0);
        chk("b2b_p_data", {24'b0, P_DATA}, 32'hFF);

        // Reset during data bit 4
        Prescale = 6'd8;
        idle(4);
        send_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 8, 1'b0);
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_busy", {31'b0, Busy}, 32'd1);
        RST = 1'b0;
        #1;
        chk("mrst_p_data", {24'b0, P_DATA}, 32'd0);
        chk("mrst_busy", {31'b0, Busy}, 32'd0);
        chk("mrst_flags", {29'b0, Data_Valid, Par_Err, Stp_Err}, 32'd0);
        last_good = 8'h00;
        RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(4);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_pending", sb.size(), 32'd0);
        chk("post_rst_p_data", {24'b0, P_DATA}, 32'h81);

`ifdef UART_RX_MAJORITY_EN
        // Single-cycle inverted spike at the sample point of every data bit
        idle(4);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("maj_pending", sb.size(), 32'd0);
        chk("maj_p_data", {24'b0, P_DATA}, 32'h96);
`endif

        idle(8);
        chk("final_pending", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
